// File: rtl/sprite_pixel_gen_pkg.sv
// Shared types, attribute bit positions and helpers for the sprite pixel generator.
package sprite_pkg;
  localparam logic [8:0] FETCH_BASE     = 9'd256;
  localparam int         ATTR_PAL_LO    = 0;
  localparam int         ATTR_PAL_HI    = 1;
  localparam int         ATTR_PRIO      = 5;
  localparam int         ATTR_HFLIP     = 6;
  localparam int         ATTR_VFLIP     = 7;
  localparam logic [7:0] EMPTY_ROW_MASK = 8'hF0;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       spr0;
  } spr_slot_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] d);
    for (int i = 0; i < 8; i++) bit_rev8[i] = d[7-i];
  endfunction

  function automatic logic [3:0] eff_row(input logic [3:0] row, input logic vflip);
    eff_row = vflip ? ~row : row;
  endfunction
endpackage

// File: rtl/sprite_pixel_gen_if.sv
// Fetch-side bus: temp-RAM bytes and pattern memory address/data.
interface sprite_pixel_gen_if;
  logic [7:0]  oam_bus;
  logic [7:0]  vram_data;
  logic [12:0] vram_addr;

  modport master (input oam_bus, input vram_data, output vram_addr);
  modport slave  (output oam_bus, output vram_data, input vram_addr);
endinterface

// File: rtl/sprite_pixel_gen_slot.sv
// One sprite slot: latches temp-RAM bytes and pattern planes, then counts down X
// and shifts its planes out during the visible line.
module sprite_slot
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       fetch_en,
  input  logic       render,
  input  logic [2:0] k,
  input  logic [7:0] oam_bus,
  input  logic [7:0] vram_data,
  input  logic       spr0_in,
  output logic [3:0] row_lo,
  output logic [7:0] tile,
  output logic       vflip,
  output logic [1:0] pal,
  output logic       prio,
  output logic [1:0] pat,
  output logic       spr0
);
  spr_slot_t  st;
  logic       empty;
  logic [7:0] pdata;
  logic [2:0] unused_attr;

  // Evaluator fills unused slots with FF, so any high row bit marks the slot empty.
  assign empty = |(st.row & EMPTY_ROW_MASK);
  assign pdata = empty ? 8'h00 : (st.attr[ATTR_HFLIP] ? bit_rev8(vram_data) : vram_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= '0;
    end else if (ce) begin
      if (fetch_en) begin
        case (k)
          3'd0: begin st.row <= oam_bus; st.spr0 <= spr0_in; end
          3'd1: st.tile <= oam_bus;
          3'd2: st.attr <= oam_bus;
          3'd3: st.x    <= oam_bus;
          3'd5: st.lo   <= pdata;
          3'd7: st.hi   <= pdata;
          default: ;
        endcase
      end else if (render) begin
        if (st.x != 8'd0) st.x <= st.x - 8'd1;
        else begin
          st.lo <= {st.lo[6:0], 1'b0};
          st.hi <= {st.hi[6:0], 1'b0};
        end
      end
    end
  end

  assign row_lo      = st.row[3:0];
  assign tile        = st.tile;
  assign vflip       = st.attr[ATTR_VFLIP];
  assign pal         = st.attr[ATTR_PAL_HI:ATTR_PAL_LO];
  assign prio        = st.attr[ATTR_PRIO];
  assign pat         = (st.x == 8'd0) ? {st.hi[7], st.lo[7]} : 2'b00;
  assign spr0        = st.spr0;
  assign unused_attr = st.attr[4:2];
endmodule

// File: rtl/sprite_pixel_gen.sv
// Sprite pixel generator: fetches 8 slots in cycles 256-319, renders them on the next line.
// Optional left-edge clipping is built when SPR_CLIP_LEFT_EN is defined.
module sprite_pixel_gen
  import sprite_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      enable,
  input  logic [8:0]                cycle,
  input  logic                      obj_size,
  input  logic                      obj_patt,
  input  logic                      sprite0,
  input  logic                      clip_left,
  sprite_pixel_gen_if.master        bus,
  output logic [3:0]                pix,
  output logic                      pix_prio,
  output logic                      pix_spr0
);
  logic       in_win, render, clip, found, show;
  logic [2:0] s, k;
  logic [3:0] er;
  logic [12:0] addr;
  logic [3:0] win_pix;
  logic       win_prio, win_spr0;

  logic [NUM_SLOTS-1:0][3:0] s_row;
  logic [NUM_SLOTS-1:0][7:0] s_tile;
  logic [NUM_SLOTS-1:0][1:0] s_pal, s_pat;
  logic [NUM_SLOTS-1:0]      s_vflip, s_prio, s_spr0;

  assign in_win = (cycle[8:6] == FETCH_BASE[8:6]);
  assign render = ~cycle[8];
  assign s      = cycle[5:3];
  assign k      = cycle[2:0];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_slot u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (ce),
      .fetch_en (in_win && (s == 3'(g))),
      .render   (render),
      .k        (k),
      .oam_bus  (bus.oam_bus),
      .vram_data(bus.vram_data),
      .spr0_in  ((g == 0) ? sprite0 : 1'b0),
      .row_lo   (s_row[g]),
      .tile     (s_tile[g]),
      .vflip    (s_vflip[g]),
      .pal      (s_pal[g]),
      .prio     (s_prio[g]),
      .pat      (s_pat[g]),
      .spr0     (s_spr0[g])
    );
  end

  // Pattern address for the slot being fetched; k[1] selects the high plane.
  always_comb begin
    addr = '0;
    er   = eff_row(s_row[s], s_vflip[s]);
    if (in_win) begin
      if (obj_size) addr = {s_tile[s][0], s_tile[s][7:1], er[3], k[1], er[2:0]};
      else          addr = {obj_patt, s_tile[s], k[1], er[2:0]};
    end
  end
  assign bus.vram_addr = addr;

  // Scan high-to-low so the lowest-index opaque slot is the last write.
  always_comb begin
    found    = 1'b0;
    win_pix  = '0;
    win_prio = 1'b0;
    win_spr0 = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (s_pat[i] != 2'b00) begin
        found    = 1'b1;
        win_pix  = {s_pal[i], s_pat[i]};
        win_prio = s_prio[i];
        win_spr0 = (i == 0) && s_spr0[i];
      end
    end
  end

`ifdef SPR_CLIP_LEFT_EN
  assign clip = clip_left && (cycle[7:3] == 5'd0);
`else
  logic unused_clip;
  assign unused_clip = clip_left;
  assign clip        = 1'b0;
`endif

  assign show = enable && render && found && !clip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix      <= '0;
      pix_prio <= 1'b0;
      pix_spr0 <= 1'b0;
    end else if (ce) begin
      pix      <= show ? win_pix : 4'h0;
      pix_prio <= show && win_prio;
      pix_spr0 <= show && win_spr0;
    end
  end
endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Directed bench for sprite_pixel_gen: fetch window addressing, rendering, priority, reset.
module tb_sprite_pixel_gen;
  logic       clk = 1'b0;
  logic       reset_n, ce, enable, obj_size, obj_patt, sprite0, clip_left;
  logic [8:0] cycle;
  logic [3:0] pix;
  logic       pix_prio, pix_spr0;

  sprite_pixel_gen_if bus ();

  sprite_pixel_gen dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable), .cycle(cycle),
    .obj_size(obj_size), .obj_patt(obj_patt), .sprite0(sprite0),
    .clip_left(clip_left), .bus(bus), .pix(pix), .pix_prio(pix_prio),
    .pix_spr0(pix_spr0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  s_row[8], s_tile[8], s_attr[8], s_x[8], s_lo[8], s_hi[8];
  logic [12:0] addr4, addr6;
  logic [3:0]  pix_log[256];
  logic        prio_log[256], spr0_log[256];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      s_row[i] = 8'hFF; s_tile[i] = 8'h00; s_attr[i] = 8'h00;
      s_x[i] = 8'h00; s_lo[i] = 8'h00; s_hi[i] = 8'h00;
    end
  endtask

  // Records slot 0 addresses at k=4 and k=6 just before the latching edge.
  task automatic run_fetch();
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 8; k++) begin
        cycle = 9'(256 + s * 8 + k);
        case (k)
          0: bus.oam_bus = s_row[s];
          1: bus.oam_bus = s_tile[s];
          2: bus.oam_bus = s_attr[s];
          3: bus.oam_bus = s_x[s];
          default: bus.oam_bus = 8'h00;
        endcase
        bus.vram_data = (k < 6) ? s_lo[s] : s_hi[s];
        #1;
        if (s == 0 && k == 4) addr4 = bus.vram_addr;
        if (s == 0 && k == 6) addr6 = bus.vram_addr;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic render_range(input int a, input int b, input logic en);
    for (int x = a; x <= b; x++) begin
      enable = en;
      cycle  = 9'(x);
      @(posedge clk); #1;
      pix_log[x] = pix; prio_log[x] = pix_prio; spr0_log[x] = pix_spr0;
    end
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; enable = 1'b1; obj_size = 1'b0; obj_patt = 1'b0;
    sprite0 = 1'b0; clip_left = 1'b0; cycle = 9'd0;
    bus.oam_bus = 8'h00; bus.vram_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix", 16'(pix), 16'h0);
    chk("rst_prio", 16'(pix_prio), 16'h0);
    chk("rst_spr0", 16'(pix_spr0), 16'h0);
    chk("rst_addr", 16'(bus.vram_addr), 16'h0);
    reset_n = 1'b1;

    // Basic 8x8 slot: address, X delay, plane order
    clear_slots();
    obj_patt = 1'b1;
    s_row[0] = 8'd3; s_tile[0] = 8'h42; s_attr[0] = 8'h01; s_x[0] = 8'd10;
    s_lo[0] = 8'hF0; s_hi[0] = 8'h0F;
    run_fetch();
    chk("addr_k4", 16'(addr4), 16'h1423);
    chk("addr_k6", 16'(addr6), 16'h142B);
    render_range(0, 255, 1'b1);
    chk("basic_x9", 16'(pix_log[9]), 16'h0);
    for (int x = 10; x <= 13; x++) chk("basic_lo", 16'(pix_log[x]), 16'h5);
    for (int x = 14; x <= 17; x++) chk("basic_hi", 16'(pix_log[x]), 16'h6);
    chk("basic_x18", 16'(pix_log[18]), 16'h0);
    cycle = 9'd330; @(posedge clk); #1;
    chk("idle_330", 16'(pix), 16'h0);

    // Horizontal flip
    clear_slots();
    s_row[0] = 8'd0; s_attr[0] = 8'h40; s_x[0] = 8'd30; s_lo[0] = 8'h80;
    run_fetch();
    render_range(0, 255, 1'b1);
    chk("hflip_x30", 16'(pix_log[30]), 16'h0);
    chk("hflip_x36", 16'(pix_log[36]), 16'h0);
    chk("hflip_x37", 16'(pix_log[37]), 16'h1);
    chk("hflip_x38", 16'(pix_log[38]), 16'h0);

    // Vertical flip, 8x16
    clear_slots();
    obj_size = 1'b1;
    s_row[0] = 8'd2; s_tile[0] = 8'h43; s_attr[0] = 8'h80; s_x[0] = 8'd50; s_lo[0] = 8'hFF;
    run_fetch();
    chk("vflip_k4", 16'(addr4), 16'h1435);
    chk("vflip_k6", 16'(addr6), 16'h143D);
    render_range(0, 255, 1'b1);
    chk("vflip_x50", 16'(pix_log[50]), 16'h1);
    obj_size = 1'b0;

    // Empty slot ignores pattern data
    clear_slots();
    s_x[0] = 8'd0; s_lo[0] = 8'hFF; s_hi[0] = 8'hFF; s_attr[0] = 8'h03;
    run_fetch();
    render_range(0, 255, 1'b1);
    begin
      int nz = 0;
      for (int x = 0; x < 256; x++) if (pix_log[x] != 4'h0) nz++;
      chk("empty_nz", 16'(nz), 16'h0);
    end

    // Overlap priority and sprite-0 flag
    clear_slots();
    sprite0 = 1'b1;
    s_row[0] = 8'd0; s_attr[0] = 8'h22; s_x[0] = 8'd20; s_lo[0] = 8'hFF;
    s_row[1] = 8'd0; s_attr[1] = 8'h03; s_x[1] = 8'd20; s_lo[1] = 8'hFF; s_hi[1] = 8'hFF;
    run_fetch();
    render_range(0, 255, 1'b1);
    chk("ovl_pix", 16'(pix_log[20]), 16'h9);
    chk("ovl_prio", 16'(prio_log[20]), 16'h1);
    chk("ovl_spr0", 16'(spr0_log[20]), 16'h1);
    run_fetch();
    render_range(0, 255, 1'b0);
    chk("dis_pix", 16'(pix_log[20]), 16'h0);
    s_lo[0] = 8'h00;
    run_fetch();
    render_range(0, 255, 1'b1);
    chk("ovl1_pix", 16'(pix_log[20]), 16'hF);
    chk("ovl1_prio", 16'(prio_log[20]), 16'h0);
    chk("ovl1_spr0", 16'(spr0_log[20]), 16'h0);
    sprite0 = 1'b0;

    // X=255 shows only the first pixel, then nothing outside the line
    clear_slots();
    s_row[0] = 8'd0; s_x[0] = 8'd255; s_lo[0] = 8'hC0; s_hi[0] = 8'hC0;
    run_fetch();
    render_range(0, 255, 1'b1);
    chk("x255_254", 16'(pix_log[254]), 16'h0);
    chk("x255_255", 16'(pix_log[255]), 16'h3);
    cycle = 9'd330; @(posedge clk); #1;
    chk("x255_330", 16'(pix), 16'h0);

    // Left-edge clipping
    clear_slots();
    clip_left = 1'b1;
    s_row[0] = 8'd0; s_x[0] = 8'd4; s_lo[0] = 8'hFF; s_hi[0] = 8'hFF;
    run_fetch();
    render_range(0, 255, 1'b1);
`ifdef SPR_CLIP_LEFT_EN
    for (int x = 4; x <= 7; x++) chk("clip_hidden", 16'(pix_log[x]), 16'h0);
`else
    for (int x = 4; x <= 7; x++) chk("clip_ignored", 16'(pix_log[x]), 16'h3);
`endif
    for (int x = 8; x <= 11; x++) chk("clip_shown", 16'(pix_log[x]), 16'h3);
    clip_left = 1'b0;

    // Reset pulse mid-render
    clear_slots();
    s_row[0] = 8'd0; s_x[0] = 8'd98; s_lo[0] = 8'hFF; s_hi[0] = 8'hFF;
    run_fetch();
    render_range(0, 99, 1'b1);
    chk("mid_pre", 16'(pix_log[99]), 16'h3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pix", 16'(pix), 16'h0);
    #1;
    reset_n = 1'b1;
    render_range(100, 255, 1'b1);
    begin
      int nz = 0;
      for (int x = 100; x < 256; x++) if (pix_log[x] != 4'h0) nz++;
      chk("mid_rest", 16'(nz), 16'h0);
    end
    chk("mid_x101", 16'(pix_log[101]), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
